lc_sweep: RTL and testbench

LC_SWEEP -- requirements
Module: lc_sweep

---
 rtl/lc_sweep.sv | 130 +++++++++++++
 tb/tb_lc_sweep.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc_sweep.sv
// rtl/lc_sweep.sv - exhaustive truth-table sweep of an external combinational circuit; optional checker under LC_SWEEP_CHECK_EN
module lc_sweep #(
    parameter int N    = 2,
    parameter int HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dut_in,
`ifdef LC_SWEEP_CHECK_EN
    input  logic [(1<<N)-1:0]  expected,
    output logic [N:0]         err_cnt,
    output logic               pass,
`endif
    output logic [N-1:0]       vec_out,
    output logic               busy,
    output logic               done,
    output logic [(1<<N)-1:0]  result
);

    localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);
    localparam logic [N-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] hold_cnt;
    logic       accept;
    logic       sample;
    logic       last_vec;

    // A start only counts while idle; a sample happens on the last hold cycle of each vector.
    assign accept   = (state == IDLE) && start;
    assign sample   = (state == SETTLE) && (hold_cnt == HOLD_LAST);
    assign last_vec = (vec_out == VEC_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the sweep ends on the sample of the all-ones vector.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (sample && last_vec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state so done lasts exactly the DONE cycle.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SETTLE:  busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Sweep datapath: hold counter, vector stepping and truth-table capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_out  <= '0;
            hold_cnt <= '0;
            result   <= '0;
        end else if (accept) begin
            vec_out  <= '0;
            hold_cnt <= '0;
            result   <= '0;
        end else if (state == SETTLE) begin
            if (sample) begin
                result[vec_out] <= dut_in;
                if (last_vec) begin
                    // Vector stays at all-ones; it must not wrap back to zero.
                    hold_cnt <= hold_cnt + 8'd1;
                end else begin
                    vec_out  <= vec_out + N'(1);
                    hold_cnt <= '0;
                end
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

`ifdef LC_SWEEP_CHECK_EN
    logic [(1<<N)-1:0] exp_q;
    logic              mismatch;
    logic [N:0]        err_next;

    // Compare each sample against the reference captured when the sweep was accepted.
    assign mismatch = sample && (dut_in != exp_q[vec_out]);
    assign err_next = err_cnt + {{N{1'b0}}, mismatch};

    // Checker state: error count per sweep, pass flag settles together with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q   <= '0;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (accept) begin
            exp_q   <= expected;
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (sample) begin
            err_cnt <= err_next;
            if (last_vec) begin
                pass <= (err_next == '0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lc_sweep.sv
// tb/tb_lc_sweep.sv - scoreboard bench for lc_sweep (N=2/HOLD=4 and N=1/HOLD=1 instances)
module tb_lc_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic       mode_a;
    logic       din_a;
    logic       din_b;
    logic [1:0] vec_a;
    logic [0:0] vec_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [3:0] res_a;
    logic [1:0] res_b;
`ifdef LC_SWEEP_CHECK_EN
    logic [3:0] exp_a;
    logic [2:0] err_a;
    logic       pass_a;
    logic [1:0] exp_b;
    logic [1:0] err_b;
    logic       pass_b;
`endif

    // Circuits under test: implication (or constant one) for A, inverter for B.
    always_comb din_a = mode_a ? 1'b1 : ((vec_a[1] & vec_a[0]) | ~vec_a[0]);
    always_comb din_b = ~vec_b[0];

    lc_sweep #(.N(2), .HOLD(4)) u_a (
        .clk(clk),
        .rst_n(rst_n),
        .start(start_a),
        .dut_in(din_a),
`ifdef LC_SWEEP_CHECK_EN
        .expected(exp_a),
        .err_cnt(err_a),
        .pass(pass_a),
`endif
        .vec_out(vec_a),
        .busy(busy_a),
        .done(done_a),
        .result(res_a)
    );

    lc_sweep #(.N(1), .HOLD(1)) u_b (
        .clk(clk),
        .rst_n(rst_n),
        .start(start_b),
        .dut_in(din_b),
`ifdef LC_SWEEP_CHECK_EN
        .expected(exp_b),
        .err_cnt(err_b),
        .pass(pass_b),
`endif
        .vec_out(vec_b),
        .busy(busy_b),
        .done(done_b),
        .result(res_b)
    );

    typedef struct {
        int         edge_no;
        logic [3:0] res;
        logic [2:0] err;
        logic       pass;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;
    int   compared   = 0;
    int   mismatched = 0;
    int   ecount     = 0;
    int   dones_a    = 0;
    int   dones_b    = 0;

    always @(posedge clk) ecount = ecount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared = compared + 1;
        if (act !== req) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse pops one expectation and is checked against it.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            dones_a = dones_a + 1;
            if (qa.size() == 0) begin
                check("a_unexpected_done", 1, 0);
            end else begin
                ea = qa.pop_front();
                check("a_done_edge", ecount, ea.edge_no);
                check("a_result", res_a, ea.res);
                check("a_busy_at_done", busy_a, 0);
`ifdef LC_SWEEP_CHECK_EN
                check("a_err_cnt", err_a, ea.err);
                check("a_pass", pass_a, ea.pass);
`endif
            end
        end
        if (done_b === 1'b1) begin
            dones_b = dones_b + 1;
            if (qb.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                eb = qb.pop_front();
                check("b_done_edge", ecount, eb.edge_no);
                check("b_result", res_b, eb.res);
                check("b_busy_at_done", busy_b, 0);
`ifdef LC_SWEEP_CHECK_EN
                check("b_err_cnt", err_b, eb.err);
                check("b_pass", pass_b, eb.pass);
`endif
            end
        end
    end

    // Called at a falling edge: the next rising edge accepts the start.
    task automatic pulse_a(input logic [3:0] r, input logic [2:0] er, input logic ps);
        exp_t e;
        e.edge_no = ecount + 1 + 16;
        e.res     = r;
        e.err     = er;
        e.pass    = ps;
        qa.push_back(e);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [1:0] r, input logic [2:0] er, input logic ps);
        exp_t e;
        e.edge_no = ecount + 1 + 2;
        e.res     = {2'b00, r};
        e.err     = er;
        e.pass    = ps;
        qb.push_back(e);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(name, qa.size() + qb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int   k;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 1'b0;
`ifdef LC_SWEEP_CHECK_EN
        exp_a = 4'b0000;
        exp_b = 2'b00;
`endif
        repeat (3) @(negedge clk);
        check("rst_vec_a", vec_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_result_a", res_a, 0);
        check("rst_vec_b", vec_b, 0);
        check("rst_result_b", res_b, 0);
`ifdef LC_SWEEP_CHECK_EN
        check("rst_err_a", err_a, 0);
        check("rst_pass_a", pass_a, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Implication sweep with vector stepping every 4 cycles.
`ifdef LC_SWEEP_CHECK_EN
        exp_a = 4'b1101;
`endif
        pulse_a(4'b1101, 3'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check("a_vec_step", vec_a, i / 4);
            check("a_busy_step", busy_a, 1);
            @(negedge clk);
        end
        drain("a_sweep1_timeout", 40);

        // Same stimulus, reference with one wrong bit.
`ifdef LC_SWEEP_CHECK_EN
        exp_a = 4'b0101;
`endif
        pulse_a(4'b1101, 3'd1, 1'b0);
        drain("a_sweep2_timeout", 40);

        // Start held high: one sweep, DONE, then a second sweep two edges later.
        mode_a = 1'b1;
`ifdef LC_SWEEP_CHECK_EN
        exp_a = 4'b1111;
`endif
        k = ecount + 1;
        e.res = 4'b1111; e.err = 3'd0; e.pass = 1'b1;
        e.edge_no = k + 16;
        qa.push_back(e);
        e.edge_no = k + 34;
        qa.push_back(e);
        start_a = 1'b1;
        repeat (19) @(negedge clk);
        start_a = 1'b0;
        drain("a_held_timeout", 60);
        repeat (5) @(negedge clk);
        check("a_result_hold", res_a, 4'b1111);

        // Reset while vector 2 is applied: abort, no done.
        mode_a  = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        check("a_vec_before_rst", vec_a, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("a_vec_after_rst", vec_a, 0);
        check("a_busy_after_rst", busy_a, 0);
        check("a_result_after_rst", res_a, 0);
        check("a_done_after_rst", done_a, 0);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // Fresh sweep from vector 0 after reset.
`ifdef LC_SWEEP_CHECK_EN
        exp_a = 4'b1101;
`endif
        pulse_a(4'b1101, 3'd0, 1'b1);
        check("a_fresh_vec0", vec_a, 0);
        drain("a_sweep3_timeout", 40);

        // Minimal instance: inverter, done two edges after start.
`ifdef LC_SWEEP_CHECK_EN
        exp_b = 2'b01;
`endif
        pulse_b(2'b01, 3'd0, 1'b1);
        drain("b_sweep1_timeout", 20);
`ifdef LC_SWEEP_CHECK_EN
        exp_b = 2'b11;
`endif
        pulse_b(2'b01, 3'd1, 1'b0);
        drain("b_sweep2_timeout", 20);

        check("a_done_count", dones_a, 5);
        check("b_done_count", dones_b, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
